// File: rtl/i2c_master_seq_pkg.sv
// rtl/i2c_master_seq_pkg.sv - shared types and constants for the I2C master sequencer
package i2c_pkg;

  localparam int QUARTER_DEFAULT = 250;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_ADDR     = 4'd2,
    S_ADDR_ACK = 4'd3,
    S_WDATA    = 4'd4,
    S_WACK     = 4'd5,
    S_RDATA    = 4'd6,
    S_MACK     = 4'd7,
    S_STOP     = 4'd8
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_master_seq_if.sv
// rtl/i2c_master_seq_if.sv - command handshake and two-wire bus bundle
interface i2c_master_seq_if;
  logic       req;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  req, addr, rw, wdata, sda_in,
    output ready, done, ack_err, rdata, scl, sda_out
  );

  modport slave (
    output req, addr, rw, wdata, sda_in,
    input  ready, done, ack_err, rdata, scl, sda_out
  );
endinterface

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - quarter-period tick and phase generator
module i2c_qtick_gen #(
  parameter int QUARTER = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] phase_o
);
  localparam int CW = $clog2(QUARTER);

  logic [CW-1:0] cnt_q;
  logic [1:0]    phase_q;

  assign tick_o  = en_i && (cnt_q == CW'(QUARTER - 1));
  assign phase_o = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_q   <= '0;
        phase_q <= phase_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_master_seq.sv
// rtl/i2c_master_seq.sv - single-byte I2C master: START, address, one data byte, STOP
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int QUARTER = QUARTER_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_master_seq_if.master bus
);
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] wdata_q, shreg_q, rdata_q, tx_byte;
  logic       ack_err_q, done_q, scl_q, sda_q, scl_d, sda_d;
  logic       sync1_q, sync2_q;
  logic       tick, busy, accept, cell_end, smp_tick;
  logic [1:0] phase, phase_nx;

  assign busy     = (state_q != S_IDLE);
  assign accept   = bus.req && !busy;
  assign cell_end = tick && (phase == Q3);
  assign smp_tick = tick && (phase == Q1);

  i2c_qtick_gen #(.QUARTER(QUARTER)) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (busy),
    .clr_i   (accept),
    .tick_o  (tick),
    .phase_o (phase)
  );

  // Bus levels are computed for the quarter about to start, then registered.
  assign phase_nx = accept ? Q0 : (tick ? phase + 2'd1 : phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE:     if (accept) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                  end
      S_START:    if (cell_end) state_d = S_ADDR;
      S_ADDR:     if (cell_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_ADDR_ACK;
                  end
      // ack_err_q already holds the address ACK sample from q1 of this cell
      S_ADDR_ACK: if (cell_end) begin
                    if (ack_err_q)              state_d = S_STOP;
                    else if (rw_q == RW_WRITE)  state_d = S_WDATA;
                    else                        state_d = S_RDATA;
                  end
      S_WDATA:    if (cell_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_WACK;
                  end
      S_WACK:     if (cell_end) state_d = S_STOP;
      S_RDATA:    if (cell_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_MACK;
                  end
      S_MACK:     if (cell_end) state_d = S_STOP;
      S_STOP:     if (cell_end) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scl_d   = 1'b1;
    sda_d   = 1'b1;
    tx_byte = (state_d == S_ADDR) ? {addr_q, rw_q} : wdata_q;
    case (state_d)
      S_START: begin
        scl_d = (phase_nx != Q3);
        sda_d = (phase_nx == Q0) || (phase_nx == Q1);
      end
      S_STOP: begin
        scl_d = (phase_nx != Q0);
        sda_d = (phase_nx == Q2) || (phase_nx == Q3);
      end
      S_ADDR, S_WDATA: begin
        scl_d = (phase_nx == Q1) || (phase_nx == Q2);
        sda_d = tx_byte[3'd7 - bit_cnt_d];
      end
      S_ADDR_ACK, S_WACK, S_RDATA, S_MACK: begin
        scl_d = (phase_nx == Q1) || (phase_nx == Q2);
        sda_d = 1'b1;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
    end else begin
      sync1_q <= bus.sda_in;
      sync2_q <= sync1_q;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      done_q  <= (state_q == S_STOP) && cell_end;
      if (accept) begin
        addr_q    <= bus.addr;
        rw_q      <= bus.rw;
        wdata_q   <= bus.wdata;
        ack_err_q <= 1'b0;
      end
      if (smp_tick) begin
        case (state_q)
          S_ADDR_ACK, S_WACK: if (sync2_q) ack_err_q <= 1'b1;
          S_RDATA: begin
            shreg_q <= {shreg_q[6:0], sync2_q};
            if (bit_cnt_q == 3'd7) rdata_q <= {shreg_q[6:0], sync2_q};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ready   = !busy;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;
  assign bus.scl     = scl_q;
  assign bus.sda_out = sda_q;
endmodule
